// File: rtl/barrido_pkg.sv
// Shared definitions for the mux sweep sequencer: state encoding and default sizes.
package barrido_pkg;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        ESTABLECER = 2'd1,
        CAPTURA    = 2'd2,
        FIN        = 2'd3
    } estado_t;

    localparam int N_CANALES_DEF = 4;
    localparam int ANCHO_SEL_DEF = 3;

endpackage

// File: rtl/barrido_multiplexor_siguiente_canal.sv
// Combinational priority search over the channel enable mask: next-higher
// enabled channel above the current one, and the lowest enabled channel.
module siguiente_canal #(
    parameter int N_CANALES = 4,
    parameter int ANCHO_SEL = 3
) (
    input  logic [N_CANALES-1:0] mascara,
    input  logic [ANCHO_SEL-1:0] actual,
    output logic [ANCHO_SEL-1:0] siguiente,
    output logic [ANCHO_SEL-1:0] menor,
    output logic                 hay_siguiente
);

    logic [N_CANALES-1:0] superior;

    genvar gi;
    generate
        for (gi = 0; gi < N_CANALES; gi++) begin : g_superior
            assign superior[gi] = mascara[gi] && (ANCHO_SEL'(gi) > actual);
        end
    endgenerate

    // Scanning downward lets the lowest matching index win.
    always_comb begin
        siguiente = '0;
        menor     = '0;
        for (int i = N_CANALES - 1; i >= 0; i--) begin
            if (superior[i]) siguiente = ANCHO_SEL'(i);
            if (mascara[i])  menor     = ANCHO_SEL'(i);
        end
    end

    assign hay_siguiente = |superior;

endmodule

// File: rtl/barrido_multiplexor.sv
// Sweep sequencer for a 4-to-1 mux: drives Selector across the enabled channels,
// waits ESPERA settle cycles per channel, then samples Salida_mux as a Valido pulse.
module barrido_multiplexor
    import barrido_pkg::*;
#(
    parameter int ANCHO     = 3,
    parameter int ANCHO_SEL = ANCHO_SEL_DEF,
    parameter int N_CANALES = N_CANALES_DEF,
    parameter int ESPERA    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Inicio,
    input  logic                 Detener,
    input  logic                 Continuo,
    input  logic [N_CANALES-1:0] Habilitar,
    input  logic [ANCHO-1:0]     Salida_mux,
    output logic [ANCHO_SEL-1:0] Selector,
    output logic [ANCHO-1:0]     Dato,
    output logic [ANCHO_SEL-1:0] Canal,
    output logic                 Valido,
    output logic                 Ocupado,
    output logic                 Fin
);

    localparam int ANCHO_CUENTA = (ESPERA > 1) ? $clog2(ESPERA) : 1;
    localparam logic [ANCHO_CUENTA-1:0] RECARGA = ANCHO_CUENTA'(ESPERA - 1);

    estado_t                estado_reg,   estado_next;
    logic [ANCHO_CUENTA-1:0] cuenta_reg,  cuenta_next;
    logic [N_CANALES-1:0]   mascara_reg,  mascara_next;
    logic                   continuo_reg, continuo_next;
    logic [ANCHO_SEL-1:0]   selector_reg, selector_next;
    logic [ANCHO-1:0]       dato_reg,     dato_next;
    logic [ANCHO_SEL-1:0]   canal_reg,    canal_next;
    logic                   valido_reg,   valido_next;
    logic                   ocupado_reg,  ocupado_next;
    logic                   fin_reg,      fin_next;

    logic [N_CANALES-1:0]   mascara_busqueda;
    logic [ANCHO_SEL-1:0]   canal_siguiente;
    logic [ANCHO_SEL-1:0]   canal_menor;
    logic                   hay_siguiente;

    // While idle the search looks at the live mask so the first channel is ready at Inicio.
    assign mascara_busqueda = (estado_reg == REPOSO) ? Habilitar : mascara_reg;

    siguiente_canal #(
        .N_CANALES (N_CANALES),
        .ANCHO_SEL (ANCHO_SEL)
    ) u_siguiente_canal (
        .mascara       (mascara_busqueda),
        .actual        (selector_reg),
        .siguiente     (canal_siguiente),
        .menor         (canal_menor),
        .hay_siguiente (hay_siguiente)
    );

    always_comb begin
        estado_next   = estado_reg;
        cuenta_next   = cuenta_reg;
        mascara_next  = mascara_reg;
        continuo_next = continuo_reg;
        selector_next = selector_reg;
        dato_next     = dato_reg;
        canal_next    = canal_reg;
        valido_next   = 1'b0;
        fin_next      = 1'b0;

        case (estado_reg)
            REPOSO: begin
                if (Inicio) begin
                    if (Habilitar != '0) begin
                        mascara_next  = Habilitar;
                        continuo_next = Continuo;
                        selector_next = canal_menor;
                        cuenta_next   = RECARGA;
                        estado_next   = ESTABLECER;
                    end else begin
                        estado_next   = FIN;
                    end
                end
            end
            ESTABLECER: begin
                if (Detener)
                    estado_next = REPOSO;
                else if (cuenta_reg == '0)
                    estado_next = CAPTURA;
                else
                    cuenta_next = cuenta_reg - ANCHO_CUENTA'(1);
            end
            CAPTURA: begin
                // Abort wins over the sample: the channel in progress is discarded.
                if (Detener) begin
                    estado_next = REPOSO;
                end else begin
                    dato_next   = Salida_mux;
                    canal_next  = selector_reg;
                    valido_next = 1'b1;
                    if (hay_siguiente) begin
                        selector_next = canal_siguiente;
                        cuenta_next   = RECARGA;
                        estado_next   = ESTABLECER;
                    end else if (continuo_reg) begin
                        selector_next = canal_menor;
                        cuenta_next   = RECARGA;
                        estado_next   = ESTABLECER;
                    end else begin
                        estado_next   = FIN;
                    end
                end
            end
            FIN: begin
                fin_next    = 1'b1;
                estado_next = REPOSO;
            end
            default: estado_next = REPOSO;
        endcase

        ocupado_next = (estado_next == ESTABLECER) || (estado_next == CAPTURA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_reg   <= REPOSO;
            cuenta_reg   <= '0;
            mascara_reg  <= '0;
            continuo_reg <= 1'b0;
            selector_reg <= '0;
            dato_reg     <= '0;
            canal_reg    <= '0;
            valido_reg   <= 1'b0;
            ocupado_reg  <= 1'b0;
            fin_reg      <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            cuenta_reg   <= cuenta_next;
            mascara_reg  <= mascara_next;
            continuo_reg <= continuo_next;
            selector_reg <= selector_next;
            dato_reg     <= dato_next;
            canal_reg    <= canal_next;
            valido_reg   <= valido_next;
            ocupado_reg  <= ocupado_next;
            fin_reg      <= fin_next;
        end
    end

    assign Selector = selector_reg;
    assign Dato     = dato_reg;
    assign Canal    = canal_reg;
    assign Valido   = valido_reg;
    assign Ocupado  = ocupado_reg;
    assign Fin      = fin_reg;

endmodule

// File: tb/tb_barrido_multiplexor.sv
// Bench for barrido_multiplexor: mux modelled inline, scoreboard of expected samples
// with their arrival cycle, table of single sweeps plus abort/reset/ESPERA=1 sequences.
module tb_barrido_multiplexor;

    typedef struct {
        logic [2:0] canal;
        logic [2:0] dato;
        int         t;
    } esp_t;

    typedef struct {
        logic [3:0] m;
        int         n;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, inicio, inicio2, detener, continuo;
    logic [3:0] habilitar;
    logic [2:0] salida_mux, salida_mux2;
    logic [2:0] selector, dato, canal, selector2, dato2, canal2;
    logic       valido, ocupado, fin, valido2, ocupado2, fin2;

    logic [2:0] datos [4];
    esp_t       q1[$], q2[$];
    esp_t       e1, e2;
    vec_t       tabla [6];
    logic [3:0] mask1 = '0, mask2 = '0;
    int cyc = 0, total = 0, bad = 0;
    int nval1 = 0, nval2 = 0, nfin1 = 0, nfin2 = 0;
    int exp_fin1 = -1, exp_fin2 = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        salida_mux  = (selector  < 3'd4) ? datos[selector[1:0]]  : 3'b000;
        salida_mux2 = (selector2 < 3'd4) ? datos[selector2[1:0]] : 3'b000;
    end

    barrido_multiplexor #(.ANCHO(3), .ANCHO_SEL(3), .N_CANALES(4), .ESPERA(2)) dut (
        .clk(clk), .rst(rst), .Inicio(inicio), .Detener(detener), .Continuo(continuo),
        .Habilitar(habilitar), .Salida_mux(salida_mux), .Selector(selector), .Dato(dato),
        .Canal(canal), .Valido(valido), .Ocupado(ocupado), .Fin(fin)
    );

    barrido_multiplexor #(.ANCHO(3), .ANCHO_SEL(3), .N_CANALES(4), .ESPERA(1)) dut2 (
        .clk(clk), .rst(rst), .Inicio(inicio2), .Detener(detener), .Continuo(continuo),
        .Habilitar(habilitar), .Salida_mux(salida_mux2), .Selector(selector2), .Dato(dato2),
        .Canal(canal2), .Valido(valido2), .Ocupado(ocupado2), .Fin(fin2)
    );

    task automatic check(input string nombre, input int actual, input int req);
        total++;
        if (actual != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nombre, actual, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valido) begin
                nval1++;
                if (q1.size() == 0) check("valido inesperado", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    check("canal", int'(canal), int'(e1.canal));
                    check("dato", int'(dato), int'(e1.dato));
                    check("ciclo valido", cyc, e1.t);
                    $display("muestra dut1: canal=%0d dato=%b ciclo=%0d", canal, dato, cyc);
                end
            end
            if (fin) begin
                nfin1++;
                check("ciclo fin", cyc, exp_fin1);
            end
            if (ocupado) check("selector habilitado", int'(selector < 3'd4 && mask1[selector[1:0]]), 1);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valido2) begin
                nval2++;
                if (q2.size() == 0) check("valido2 inesperado", 1, 0);
                else begin
                    e2 = q2.pop_front();
                    check("canal2", int'(canal2), int'(e2.canal));
                    check("dato2", int'(dato2), int'(e2.dato));
                    check("ciclo valido2", cyc, e2.t);
                    $display("muestra dut2: canal=%0d dato=%b ciclo=%0d", canal2, dato2, cyc);
                end
            end
            if (fin2) begin
                nfin2++;
                check("ciclo fin2", cyc, exp_fin2);
            end
            if (ocupado2) check("selector2 habilitado", int'(selector2 < 3'd4 && mask2[selector2[1:0]]), 1);
        end
    end

    // Starts a sweep on dut (d=1, ESPERA=2) or dut2 (d=2, ESPERA=1) and queues the expected
    // samples; in continuous mode n samples are queued.
    task automatic arrancar(input int d, input logic [3:0] m, input logic cont, input int n);
        int esp, base, cnt;
        logic [2:0] lista[$];
        esp = (d == 1) ? 2 : 1;
        for (int i = 0; i < 4; i++) if (m[i]) lista.push_back(3'(i));
        @(negedge clk);
        habilitar = m;
        continuo  = cont;
        if (d == 1) begin inicio = 1'b1; mask1 = m; end
        else        begin inicio2 = 1'b1; mask2 = m; end
        @(posedge clk); #1;
        inicio  = 1'b0;
        inicio2 = 1'b0;
        base = cyc;
        cnt = cont ? n : lista.size();
        for (int j = 0; j < cnt && lista.size() > 0; j++) begin
            esp_t e;
            e.canal = lista[j % lista.size()];
            e.dato  = datos[e.canal[1:0]];
            e.t     = base + (esp + 1) * (j + 1);
            if (d == 1) q1.push_back(e); else q2.push_back(e);
        end
        if (cont) begin
            if (d == 1) exp_fin1 = -1; else exp_fin2 = -1;
        end else begin
            if (d == 1) exp_fin1 = base + (esp + 1) * lista.size() + 1;
            else        exp_fin2 = base + (esp + 1) * lista.size() + 1;
        end
        $display("inicio dut%0d: mascara=%b continuo=%0d ciclo=%0d", d, m, cont, base);
    endtask

    task automatic esperar(input int d);
        int i;
        i = 0;
        while (i < 200 && ((d == 1) ? (q1.size() != 0 || ocupado) : (q2.size() != 0 || ocupado2))) begin
            @(negedge clk); #1;
            i++;
        end
        check("espera acotada", int'(i < 200), 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout global: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        datos = '{3'b001, 3'b100, 3'b101, 3'b110};
        tabla[0] = '{4'b1111, 4};
        tabla[1] = '{4'b1010, 2};
        tabla[2] = '{4'b0000, 0};
        tabla[3] = '{4'b0101, 2};
        tabla[4] = '{4'b1000, 1};
        tabla[5] = '{4'b0110, 2};

        rst = 1'b1; inicio = 1'b0; inicio2 = 1'b0; detener = 1'b0; continuo = 1'b0;
        habilitar = 4'b0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset selector", int'(selector), 0);
        check("reset dato", int'(dato), 0);
        check("reset canal", int'(canal), 0);
        check("reset valido", int'(valido), 0);
        check("reset ocupado", int'(ocupado), 0);
        check("reset fin", int'(fin), 0);

        // Single sweeps; a mid-sweep Inicio with a different mask/mode must be ignored.
        foreach (tabla[k]) begin
            nval1 = 0; nfin1 = 0;
            arrancar(1, tabla[k].m, 1'b0, 0);
            repeat (4) @(negedge clk);
            #1;
            if (ocupado) begin
                inicio = 1'b1; habilitar = ~tabla[k].m; continuo = 1'b1;
                @(posedge clk); #1;
                inicio = 1'b0;
            end
            esperar(1);
            check("num valido", nval1, tabla[k].n);
            check("num fin", nfin1, 1);
            check("ocupado al final", int'(ocupado), 0);
        end

        // Continuous wrap on 0011, abort after the fifth sample.
        nval1 = 0; nfin1 = 0;
        arrancar(1, 4'b0011, 1'b1, 5);
        for (int i = 0; i < 100 && nval1 < 5; i++) begin @(negedge clk); #1; end
        check("cinco muestras", nval1, 5);
        detener = 1'b1;
        @(posedge clk); #1;
        detener = 1'b0;
        check("ocupado tras detener", int'(ocupado), 0);
        repeat (10) @(negedge clk);
        #1;
        check("sin mas muestras", nval1, 5);
        check("sin fin tras detener", nfin1, 0);

        // Detener arriving on the capture edge of the first channel suppresses its sample.
        nval1 = 0; nfin1 = 0;
        arrancar(1, 4'b1111, 1'b0, 0);
        repeat (3) @(negedge clk);
        detener = 1'b1;
        @(posedge clk); #1;
        detener = 1'b0;
        q1.delete();
        exp_fin1 = -1;
        check("ocupado tras detener captura", int'(ocupado), 0);
        repeat (10) @(negedge clk);
        #1;
        check("captura abortada", nval1, 0);
        check("sin fin captura abortada", nfin1, 0);

        // Reset while channel 2 is settling.
        nval1 = 0; nfin1 = 0;
        arrancar(1, 4'b1111, 1'b0, 0);
        for (int i = 0; i < 50 && selector != 3'd2; i++) begin @(negedge clk); #1; end
        check("selector en 2", int'(selector), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst selector", int'(selector), 0);
        check("rst dato", int'(dato), 0);
        check("rst canal", int'(canal), 0);
        check("rst valido", int'(valido), 0);
        check("rst ocupado", int'(ocupado), 0);
        check("rst fin", int'(fin), 0);
        q1.delete();
        exp_fin1 = -1;
        repeat (12) @(negedge clk);
        #1;
        check("muestras antes de rst", nval1, 2);
        check("sin fin tras rst", nfin1, 0);

        // ESPERA=1 instance: two-cycle spacing, same data.
        nval2 = 0; nfin2 = 0;
        arrancar(2, 4'b1111, 1'b0, 0);
        esperar(2);
        check("num valido espera1", nval2, 4);
        check("num fin espera1", nfin2, 1);
        check("ocupado2 al final", int'(ocupado2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
